vga_scan_ctrl: RTL

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_scan_ctrl.sv | 94 +++++++++
 1 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: pixel-clock enable, h/v position counters,
// registered sync/blank decode aligned with DrawX/DrawY, and a frame_start
// pulse at the top of vertical blanking.
module vga_scan_ctrl #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam int unsigned CW = 10;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic          pix_en;
  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] hc_next;
  logic [CW-1:0] vc_next;
  logic          line_wrap;

  // Next raster position; only moves on pixel-enable edges
  always_comb begin
    hc_next   = hc;
    vc_next   = vc;
    line_wrap = 1'b0;
    if (pix_en) begin
      if (hc == H_LAST) begin
        hc_next   = '0;
        line_wrap = 1'b1;
        if (vc == V_LAST) begin
          vc_next = '0;
        end else begin
          vc_next = vc + CW'(1);
        end
      end else begin
        hc_next = hc + CW'(1);
      end
    end
  end

  // Counters plus sync/blank decoded from the next position so they change
  // on the same edge as DrawX/DrawY
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_en      <= 1'b0;
      hc          <= '0;
      vc          <= '0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      hc          <= hc_next;
      vc          <= vc_next;
      VGA_HS      <= !((hc_next >= HS_START) && (hc_next < HS_END));
      VGA_VS      <= !((vc_next >= VS_START) && (vc_next < VS_END));
      VGA_BLANK_N <= (hc_next < H_VIS) && (vc_next < V_VIS);
      frame_start <= line_wrap && (vc_next == V_VIS);
    end
  end

  assign VGA_CLK    = pix_en;
  assign VGA_SYNC_N = 1'b0;
  assign DrawX      = hc;
  assign DrawY      = vc;

endmodule
